memory_port_arbiter: RTL

//  Shares one pipelined memory port (wait_req/valid handshake, in-order read responses) between the

---
 rtl/memory_port_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
//   Shares one pipelined memory port between the instruction fetch requester and the
//   load/store requester. Every accepted read pushes its owner into a tag FIFO. In-order
//   read responses are steered to the owner at the FIFO head.
// Ports
//   clock, reset                       system clock, synchronous active-high reset
//   inst_*                             fetch request (read only) and its response
//   data_*                             load/store request and load response
//   mem_*                              the single external memory port (wait_req/valid handshake)
//   proto_error                        sticky flag: a response arrived with no read outstanding
module memory_port_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inst_address,
    input  logic        inst_read_enable,
    output logic        inst_wait_req,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    input  logic [31:0] data_address,
    input  logic        data_read_enable,
    input  logic        data_write_enable,
    input  logic [31:0] data_write_data,
    input  logic [3:0]  data_byte_enable,
    output logic        data_wait_req,
    output logic        data_valid,
    output logic [31:0] data_read_data,
    output logic [31:0] mem_address,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_byte_enable,
    input  logic        mem_wait_req,
    input  logic        mem_valid,
    input  logic [31:0] mem_read_data,
    output logic        proto_error
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_state_t;

    lock_state_t                lock_q, lock_d;
    logic [MAX_OUTSTANDING-1:0] tag_q;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]           count_q;
    logic [STV_W-1:0]           starve_q;

    logic grant_inst, grant_data;
    logic inst_ok, data_ok;
    logic fifo_full, fifo_empty, starve_hit;
    logic read_push, resp_pop, inst_accept;

    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign starve_hit = (starve_q == STV_W'(STARVE_LIMIT));

    // Lock state register
    always_ff @(posedge clock) begin
        if (reset) lock_q <= LOCK_NONE;
        else       lock_q <= lock_d;
    end

    // Grant selection, lock next-state and memory port steering
    always_comb begin
        grant_inst       = 1'b0;
        grant_data       = 1'b0;
        lock_d           = LOCK_NONE;
        inst_ok          = inst_read_enable && !fifo_full;
        data_ok          = data_write_enable || (data_read_enable && !fifo_full);
        mem_address      = inst_address;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_write_data   = data_write_data;
        mem_byte_enable  = 4'b1111;
        inst_wait_req    = 1'b1;
        data_wait_req    = 1'b1;

        unique case (lock_q)
            LOCK_INST: grant_inst = inst_ok;
            LOCK_DATA: grant_data = data_ok;
            default: begin
                // Data has priority unless fetch has been starved long enough to win once
                if (data_ok && !(starve_hit && inst_ok)) grant_data = 1'b1;
                else if (inst_ok)                        grant_inst = 1'b1;
            end
        endcase

        if (reset) begin
            grant_inst = 1'b0;
            grant_data = 1'b0;
        end

        // A stalled grant keeps the port until the memory takes it
        if (grant_data && mem_wait_req)      lock_d = LOCK_DATA;
        else if (grant_inst && mem_wait_req) lock_d = LOCK_INST;

        if (grant_data) begin
            mem_address      = data_address;
            mem_read_enable  = data_read_enable;
            mem_write_enable = data_write_enable;
            mem_byte_enable  = data_write_enable ? data_byte_enable : 4'b1111;
            data_wait_req    = mem_wait_req;
        end else if (grant_inst) begin
            mem_read_enable  = 1'b1;
            inst_wait_req    = mem_wait_req;
        end
    end

    assign inst_accept = grant_inst && !mem_wait_req;
    assign read_push   = mem_read_enable && !mem_wait_req;
    assign resp_pop    = mem_valid && !fifo_empty;

    // Response steering by the owner at the FIFO head
    always_comb begin
        inst_valid     = 1'b0;
        data_valid     = 1'b0;
        inst_data      = mem_read_data;
        data_read_data = mem_read_data;
        if (resp_pop && !reset) begin
            inst_valid = !tag_q[rd_ptr_q];
            data_valid =  tag_q[rd_ptr_q];
        end
    end

    // Tag FIFO, starvation counter and protocol error flag
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            proto_error <= 1'b0;
        end else begin
            if (read_push) begin
                tag_q[wr_ptr_q] <= grant_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (resp_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);

            if (read_push && !resp_pop)      count_q <= count_q + CNT_W'(1);
            else if (!read_push && resp_pop) count_q <= count_q - CNT_W'(1);

            if (inst_accept)                         starve_q <= '0;
            else if (inst_read_enable && !starve_hit) starve_q <= starve_q + STV_W'(1);

            if (mem_valid && fifo_empty) proto_error <= 1'b1;
        end
    end

endmodule
